// File: rtl/pcap_replay_pkg.sv
// rtl/pcap_replay_pkg.sv - shared FSM encoding and memory-word field offsets
package pcap_replay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_WAIT   = 2'd3
   } state_t;

   // Memory word layout, LSB first: tdata, tuser, tstrb, tlast
   function automatic int TUSER_LSB(input int dw);
      return dw;
   endfunction

   function automatic int TSTRB_LSB(input int dw, input int uw);
      return dw + uw;
   endfunction

   function automatic int TLAST_POS(input int dw, input int uw);
      return dw + uw + dw / 8;
   endfunction

endpackage

// File: rtl/replay_fifo.sv
// rtl/replay_fifo.sv - synchronous show-ahead FIFO with occupancy count
module replay_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_clr,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_rd_en && (r_count != '0);
   assign w_push = i_wr_en && ((r_count != L_FULL) || w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = (r_count == L_FULL);
   assign o_empty   = (r_count == '0);

endmodule

// File: rtl/pcap_replay_sequencer.sv
// rtl/pcap_replay_sequencer.sv - round-robin multi-channel memory replay onto an AXI-Stream master
module pcap_replay_sequencer
   import pcap_replay_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int MEM_ADDR_WIDTH       = 19,
   parameter int REPLAY_COUNT_WIDTH   = 32,
   parameter int NUM_CHANNELS         = 4,
   parameter int FIFO_DEPTH           = 16
) (
   input  logic                                           axi_aclk,
   input  logic                                           axi_aresetn,
   input  logic                                           sw_rst,
   input  logic                                           start_replay,
   input  logic [NUM_CHANNELS-1:0]                        chan_en,
   input  logic [NUM_CHANNELS*MEM_ADDR_WIDTH-1:0]         addr_low,
   input  logic [NUM_CHANNELS*MEM_ADDR_WIDTH-1:0]         addr_high,
   input  logic [NUM_CHANNELS*REPLAY_COUNT_WIDTH-1:0]     replay_count,
   output logic                                           mem_rd_req,
   output logic [MEM_ADDR_WIDTH-1:0]                      mem_rd_addr,
   input  logic                                           mem_rd_ready,
   input  logic                                           mem_rd_valid,
   input  logic [C_M_AXIS_DATA_WIDTH/8+C_M_AXIS_TUSER_WIDTH+C_M_AXIS_DATA_WIDTH:0] mem_rd_data,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]               m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
   output logic                                           m_axis_tvalid,
   output logic                                           m_axis_tlast,
   input  logic                                           m_axis_tready,
   output logic                                           busy,
   output logic [NUM_CHANNELS-1:0]                        chan_done,
   output logic [NUM_CHANNELS-1:0]                        cfg_err
);

   localparam int W  = C_M_AXIS_DATA_WIDTH;
   localparam int TU = C_M_AXIS_TUSER_WIDTH;
   localparam int MW = 1 + W/8 + TU + W;
   localparam int AW = MEM_ADDR_WIDTH;
   localparam int RW = REPLAY_COUNT_WIDTH;
   localparam int N  = NUM_CHANNELS;
   localparam int CI = (N > 1) ? $clog2(N) : 1;
   localparam int OW = $clog2(FIFO_DEPTH) + 1;
   localparam int L_TUSER = TUSER_LSB(W);
   localparam int L_TSTRB = TSTRB_LSB(W, TU);
   localparam int L_TLAST = TLAST_POS(W, TU);

   state_t          r_state, w_next;
   logic            r_start_d, r_busy;
   logic [N-1:0]    r_en, r_done, r_err;
   logic [AW-1:0]   r_low [N];
   logic [AW-1:0]   r_high [N];
   logic [RW-1:0]   r_cnt [N];
   logic [RW-1:0]   r_pass [N];
   logic [CI-1:0]   r_chan, w_sel;
   logic [AW-1:0]   r_addr;
   logic [OW-1:0]   r_outst, r_discard, w_pending, w_fifo_cnt;
   logic [N-1:0]    w_active;
   logic            w_found, w_rise, w_accept, w_resp, w_last_addr, w_room, w_pass_done;
   logic            w_fifo_full, w_fifo_empty;
   logic [MW-1:0]   w_fifo_out;

   assign w_rise      = start_replay && !r_start_d;
   assign w_active    = r_en & ~r_err & ~r_done;
   assign w_accept    = mem_rd_req && mem_rd_ready;
   assign w_resp      = mem_rd_valid && (r_discard == '0);
   assign w_last_addr = (r_addr == r_high[r_chan]);
   assign w_room      = !w_fifo_full && ((32'(w_fifo_cnt) + 32'(r_outst)) < 32'(FIFO_DEPTH));
   assign w_pass_done = (r_state == ST_WAIT) && (r_outst == '0);
   // Reads still owed by memory when sw_rst hits; their responses must be dropped
   assign w_pending   = r_discard + r_outst + OW'(w_accept) - OW'(mem_rd_valid);

   // Nearest active channel after r_chan; smallest offset wins
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_chan;
      for (int k = N; k >= 1; k--) begin
         if (w_active[(int'(r_chan) + k) % N]) begin
            w_found = 1'b1;
            w_sel   = CI'((int'(r_chan) + k) % N);
         end
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)  r_state <= ST_IDLE;
      else if (sw_rst)   r_state <= ST_IDLE;
      else               r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_rise) w_next = ST_SELECT;
         ST_SELECT: w_next = w_found ? ST_ISSUE : ST_IDLE;
         ST_ISSUE:  if (w_accept && w_last_addr) w_next = ST_WAIT;
         ST_WAIT:   if (r_outst == '0) w_next = start_replay ? ST_SELECT : ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_rd_req = 1'b0;
      if (r_state == ST_ISSUE) mem_rd_req = w_room;
   end

   always_ff @(posedge axi_aclk) begin
      if (r_state == ST_IDLE && w_rise) begin
         for (int i = 0; i < N; i++) begin
            r_low[i]  <= addr_low[i*AW +: AW];
            r_high[i] <= addr_high[i*AW +: AW];
            r_cnt[i]  <= replay_count[i*RW +: RW];
         end
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_start_d <= 1'b0;
         r_busy    <= 1'b0;
         r_en      <= '0;
         r_done    <= '0;
         r_err     <= '0;
         r_chan    <= '0;
         r_addr    <= '0;
         r_outst   <= '0;
         r_discard <= '0;
         for (int i = 0; i < N; i++) r_pass[i] <= '0;
      end else if (sw_rst) begin
         r_start_d <= 1'b0;
         r_busy    <= 1'b0;
         r_en      <= '0;
         r_done    <= '0;
         r_err     <= '0;
         r_chan    <= '0;
         r_addr    <= '0;
         r_outst   <= '0;
         r_discard <= w_pending;
         for (int i = 0; i < N; i++) r_pass[i] <= '0;
      end else begin
         r_start_d <= start_replay;
         r_busy    <= (w_next != ST_IDLE);
         if (r_state == ST_IDLE && w_rise) begin
            r_en   <= chan_en;
            r_done <= '0;
            r_chan <= CI'(N - 1);
            for (int i = 0; i < N; i++) begin
               r_pass[i] <= '0;
               r_err[i]  <= chan_en[i] && (addr_high[i*AW +: AW] < addr_low[i*AW +: AW]);
            end
         end
         if (r_state == ST_SELECT && w_found) begin
            r_chan <= w_sel;
            r_addr <= r_low[w_sel];
         end
         if (w_accept && !w_last_addr) r_addr <= r_addr + AW'(1);
         if (w_pass_done) begin
            r_pass[r_chan] <= r_pass[r_chan] + RW'(1);
            if (r_cnt[r_chan] != '0 && (r_pass[r_chan] + RW'(1)) == r_cnt[r_chan])
               r_done[r_chan] <= 1'b1;
            if (!start_replay) r_done <= '1;
         end
         case ({w_accept, w_resp})
            2'b10:   r_outst <= r_outst + OW'(1);
            2'b01:   r_outst <= r_outst - OW'(1);
            default: r_outst <= r_outst;
         endcase
         if (mem_rd_valid && r_discard != '0) r_discard <= r_discard - OW'(1);
      end
   end

   replay_fifo #(
      .WIDTH (MW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (axi_aclk),
      .i_rst_n   (axi_aresetn),
      .i_clr     (sw_rst),
      .i_wr_en   (w_resp),
      .i_wr_data (mem_rd_data),
      .i_rd_en   (m_axis_tvalid && m_axis_tready),
      .o_rd_data (w_fifo_out),
      .o_count   (w_fifo_cnt),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   assign mem_rd_addr   = r_addr;
   assign m_axis_tvalid = !w_fifo_empty;
   assign m_axis_tdata  = w_fifo_out[W-1:0];
   assign m_axis_tuser  = w_fifo_out[L_TUSER +: TU];
   assign m_axis_tstrb  = w_fifo_out[L_TSTRB +: W/8];
   assign m_axis_tlast  = w_fifo_out[L_TLAST];
   assign busy          = r_busy;
   assign chan_done     = r_done;
   assign cfg_err       = r_err;

endmodule

// File: tb/tb_pcap_replay_sequencer.sv
// tb/tb_pcap_replay_sequencer.sv - scoreboard bench for pcap_replay_sequencer
module tb_pcap_replay_sequencer;

   localparam int W  = 256;
   localparam int TU = 128;
   localparam int MW = 1 + W/8 + TU + W;
   localparam int AW = 19;
   localparam int RW = 32;
   localparam int N  = 4;
   localparam int D  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sw_rst, start_replay;
   logic [N-1:0]      chan_en;
   logic [N*AW-1:0]   addr_low, addr_high;
   logic [N*RW-1:0]   replay_count;
   logic              mem_rd_req, mem_rd_ready, mem_rd_valid;
   logic [AW-1:0]     mem_rd_addr;
   logic [MW-1:0]     mem_rd_data;
   logic [W-1:0]      m_axis_tdata;
   logic [W/8-1:0]    m_axis_tstrb;
   logic [TU-1:0]     m_axis_tuser;
   logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic              busy;
   logic [N-1:0]      chan_done, cfg_err;

   always #5 clk = ~clk;

   pcap_replay_sequencer #(
      .C_M_AXIS_DATA_WIDTH  (W),
      .C_M_AXIS_TUSER_WIDTH (TU),
      .MEM_ADDR_WIDTH       (AW),
      .REPLAY_COUNT_WIDTH   (RW),
      .NUM_CHANNELS         (N),
      .FIFO_DEPTH           (D)
   ) dut (
      .axi_aclk      (clk),
      .axi_aresetn   (rst_n),
      .sw_rst        (sw_rst),
      .start_replay  (start_replay),
      .chan_en       (chan_en),
      .addr_low      (addr_low),
      .addr_high     (addr_high),
      .replay_count  (replay_count),
      .mem_rd_req    (mem_rd_req),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_ready  (mem_rd_ready),
      .mem_rd_valid  (mem_rd_valid),
      .mem_rd_data   (mem_rd_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .chan_done     (chan_done),
      .cfg_err       (cfg_err)
   );

   typedef struct { logic [AW-1:0] a; int due; } rsp_t;

   rsp_t           pend[$];
   logic [AW-1:0]  exp_addr[$];
   logic [MW-1:0]  exp_beat[$];
   int             vectors = 0, miscompares = 0;
   int             lat = 1, cyc = 0, n_acc = 0, n_beat = 0, max_fly = 0;
   bit             rnd_rdy = 1'b0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [MW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] s;
      s = {13'd0, a};
      return {&a[1:0], s ^ 32'h0F0F_0000, {4{s ^ 32'h1234_0000}}, {8{s ^ 32'hCAFE_0000}}};
   endfunction

   task automatic cfg(input int ch, input int lo, input int hi, input int cnt);
      addr_low[ch*AW +: AW]     = AW'(lo);
      addr_high[ch*AW +: AW]    = AW'(hi);
      replay_count[ch*RW +: RW] = RW'(cnt);
   endtask

   task automatic clr_cfg();
      chan_en = '0; addr_low = '0; addr_high = '0; replay_count = '0;
      n_acc = 0; n_beat = 0; max_fly = 0;
   endtask

   task automatic push_exp(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) begin
         exp_addr.push_back(AW'(a));
         exp_beat.push_back(mem_word(AW'(a)));
      end
   endtask

   task automatic wait_idle(input string tag);
      int i;
      i = 0;
      @(posedge clk); #1;
      while (busy && i < 2000) begin
         @(posedge clk); #1;
         i++;
      end
      if (busy) check({tag, "_idle_timeout"}, 512'(busy), 512'(0));
      repeat (20) @(posedge clk);
      #1;
      check({tag, "_addr_left"}, 512'(exp_addr.size()), 512'(0));
      check({tag, "_beat_left"}, 512'(exp_beat.size()), 512'(0));
      start_replay = 1'b0;
      @(posedge clk); #1;
   endtask

   // Memory model and output monitor, both evaluated away from the active edge
   initial begin
      logic [MW-1:0] e;
      logic [AW-1:0] ea;
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
      mem_rd_ready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (m_axis_tvalid && m_axis_tready) begin
            e = (exp_beat.size() != 0) ? exp_beat.pop_front() : '1;
            check("beat", 512'({m_axis_tlast, m_axis_tstrb, m_axis_tuser, m_axis_tdata}), 512'(e));
            n_beat++;
         end
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_word(pend[0].a);
            void'(pend.pop_front());
         end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
         end
         mem_rd_ready = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
         if (mem_rd_req && mem_rd_ready && rst_n) begin
            ea = (exp_addr.size() != 0) ? exp_addr.pop_front() : '1;
            check("rd_addr", 512'(mem_rd_addr), 512'(ea));
            pend.push_back('{mem_rd_addr, cyc + lat});
            n_acc++;
         end
         if (n_acc - n_beat > max_fly) max_fly = n_acc - n_beat;
      end
   end

   initial begin
      int i;
      sw_rst = 1'b0; start_replay = 1'b0; m_axis_tready = 1'b1;
      clr_cfg();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_busy",  512'(busy), 512'(0));
      check("rst_req",   512'(mem_rd_req), 512'(0));
      check("rst_tvalid",512'(m_axis_tvalid), 512'(0));
      check("rst_done",  512'(chan_done), 512'(0));
      check("rst_err",   512'(cfg_err), 512'(0));

      // One channel, two passes over 0..3
      clr_cfg(); lat = 1; chan_en = 4'b0001; cfg(0, 0, 3, 2);
      push_exp(0, 3); push_exp(0, 3);
      start_replay = 1'b1;
      wait_idle("t1");
      check("t1_done",  512'(chan_done), 512'(4'b0001));
      check("t1_beats", 512'(n_beat), 512'(8));

      // Channels 0 and 2 in order, channel 1 disabled
      clr_cfg(); lat = 2; chan_en = 4'b0101;
      cfg(0, 20, 22, 1); cfg(1, 30, 31, 1); cfg(2, 40, 41, 1);
      push_exp(20, 22); push_exp(40, 41);
      start_replay = 1'b1;
      wait_idle("t2");
      check("t2_done", 512'(chan_done), 512'(4'b0101));

      // Output stalled 100 cycles with latency 5 and a jittery memory
      clr_cfg(); lat = 5; rnd_rdy = 1'b1; m_axis_tready = 1'b0; chan_en = 4'b0001;
      cfg(0, 0, 39, 1); push_exp(0, 39);
      start_replay = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("t3_stall_beats", 512'(n_beat), 512'(0));
      m_axis_tready = 1'b1;
      wait_idle("t3");
      rnd_rdy = 1'b0;
      check("t3_max_inflight_ok", 512'(max_fly <= D), 512'(1));
      check("t3_beats", 512'(n_beat), 512'(40));

      // Continuous replay stopped mid-pass
      clr_cfg(); lat = 2; chan_en = 4'b0010; cfg(1, 10, 17, 0);
      push_exp(10, 17);
      start_replay = 1'b1;
      i = 0;
      while (n_acc < 3 && i < 100) begin @(posedge clk); #1; i++; end
      check("t4_midpass", 512'(n_acc >= 3 && n_acc < 8), 512'(1));
      start_replay = 1'b0;
      wait_idle("t4");
      check("t4_done", 512'(chan_done), 512'(4'b1111));
      check("t4_beats", 512'(n_beat), 512'(8));

      // Inverted range on channel 3
      clr_cfg(); lat = 1; chan_en = 4'b1001; cfg(0, 50, 51, 1); cfg(3, 5, 2, 1);
      push_exp(50, 51);
      start_replay = 1'b1;
      wait_idle("t5");
      check("t5_err",  512'(cfg_err), 512'(4'b1000));
      check("t5_done", 512'(chan_done), 512'(4'b0001));

      // sw_rst with three reads in flight, then a fresh run
      clr_cfg(); lat = 10; chan_en = 4'b0001; cfg(0, 0, 2, 1);
      push_exp(0, 2);
      start_replay = 1'b1;
      i = 0;
      while (n_acc < 3 && i < 100) begin @(posedge clk); #1; i++; end
      check("t6_acc", 512'(n_acc), 512'(3));
      sw_rst = 1'b1; start_replay = 1'b0; exp_beat.delete();
      @(posedge clk); #1;
      sw_rst = 1'b0;
      check("t6_req",    512'(mem_rd_req), 512'(0));
      check("t6_tvalid", 512'(m_axis_tvalid), 512'(0));
      check("t6_busy",   512'(busy), 512'(0));
      check("t6_done",   512'(chan_done), 512'(0));
      check("t6_pending",512'(pend.size() != 0), 512'(1));
      clr_cfg(); lat = 1; chan_en = 4'b0001; cfg(0, 4, 6, 1);
      push_exp(4, 6);
      start_replay = 1'b1;
      wait_idle("t6");
      check("t6_beats",  512'(n_beat), 512'(3));
      check("t6_done2",  512'(chan_done), 512'(4'b0001));
      check("t6_drained",512'(pend.size()), 512'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pcap_replay_sequencer.md
PCAP_REPLAY_SEQUENCER -- requirements
Module: pcap_replay_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
- C_M_AXIS_DATA_WIDTH, 256, stream data width.
- C_M_AXIS_TUSER_WIDTH, 128, stream tuser width.
- MEM_ADDR_WIDTH, 19, word address width.
- REPLAY_COUNT_WIDTH, 32, replay counter width.
- NUM_CHANNELS, 4, independent replay regions.
- FIFO_DEPTH, 16, output buffer words; power of 2, minimum 4.

REQ-002 SHALL have ports, one per line (W = C_M_AXIS_DATA_WIDTH, MW = 1 + W/8 + TUSER + W, N = NUM_CHANNELS):
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- sw_rst  in  1  synchronous clear, same effect as reset.
- start_replay  in  1  level enable; rising edge starts a run.
- chan_en  in  N  per-channel enable, sampled at run start.
- addr_low  in  N*MEM_ADDR_WIDTH  per-channel first word address.
- addr_high  in  N*MEM_ADDR_WIDTH  per-channel last word address, inclusive.
- replay_count  in  N*REPLAY_COUNT_WIDTH  passes per channel; 0 means continuous.
- mem_rd_req  out  1  read request valid.
- mem_rd_addr  out  MEM_ADDR_WIDTH  read word address.
- mem_rd_ready  in  1  request accepted when high with mem_rd_req.
- mem_rd_valid  in  1  in-order response valid; any latency.
- mem_rd_data  in  MW  {tlast, tstrb, tuser, tdata}.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  W/W/8/TUSER/1/1  stream out.
- m_axis_tready  in  1  stream back-pressure.
- busy  out  1  run in progress.
- chan_done  out  N  channel finished all passes in this run.
- cfg_err  out  N  addr_high < addr_low at run start.

Function
REQ-003 SHALL implement the FSM IDLE -> SELECT -> ISSUE -> WAIT -> SELECT | IDLE.
REQ-004 SHALL leave IDLE on a rising edge of start_replay. On that edge it latches chan_en, addresses, and counts. It clears chan_done and cfg_err and sets busy.
REQ-005 SHALL, in SELECT, pick the next active channel round-robin starting after the last serviced channel (channel 0 first after a start).
- Active channel: enabled, cfg_err clear, not done.
- If no channel is active, go to IDLE and clear busy.
REQ-006 SHALL, in ISSUE, issue one read per accepted handshake, from addr_low to addr_high inclusive, incrementing by 1.
REQ-007 SHALL only assert mem_rd_req when fifo_count + outstanding < FIFO_DEPTH, so responses never overflow the FIFO.
REQ-008 SHALL increment outstanding on a request accept and decrement it on mem_rd_valid. Both in the same cycle leave it unchanged.
REQ-009 SHALL write every mem_rd_valid word into the FIFO unconditionally. The FIFO drives m_axis_* with AXI-Stream semantics and 1-cycle write-to-tvalid latency.
REQ-010 SHALL enter WAIT after the addr_high request is accepted, and leave WAIT when outstanding == 0. On leaving, it increments that channel's pass counter.
REQ-011 SHALL set chan_done[i] when the pass counter equals replay_count[i] (replay_count 0 never completes).
REQ-012 SHALL, when start_replay is low at WAIT exit, mark every channel done and go to IDLE. The current pass always completes and no packet is truncated.
REQ-013 SHALL treat addr_low == addr_high as a valid one-word pass.
REQ-014 SHALL set cfg_err[i] for an enabled channel with addr_high < addr_low. That channel is skipped.
REQ-015 SHALL use a pass counter of REPLAY_COUNT_WIDTH bits.
REQ-016 SHALL ignore start_replay edges while busy.

Reset
REQ-017 SHALL, on axi_aresetn low (asynchronous) or sw_rst high (synchronous):
- Return the FSM to IDLE.
- Empty the FIFO and zero outstanding and all counters.
- Drive mem_rd_req, m_axis_tvalid, busy, chan_done, and cfg_err to 0.
REQ-018 SHALL discard responses arriving after a mid-run sw_rst until the outstanding count seen at reset has drained.

Structure
REQ-019 SHALL place the FSM state encoding and the MW field offsets (TLAST_POS, TSTRB_LSB, TUSER_LSB) in a shared package, pcap_replay_pkg.
REQ-020 SHALL instantiate one sub-module, replay_fifo: a synchronous show-ahead FIFO providing count, full, and empty.

Verification
REQ-021 SHALL cover, one line each:
- One channel, low=0, high=3, count=2, zero-latency memory, tready=1 -> 8 beats, addresses 0..3 twice, chan_done[0]=1, busy falls.
- Channels 0 and 2 enabled, count=1 each -> channel 0 pass fully precedes channel 2 pass; channel 1 reads none.
- tready=0 for 100 cycles, latency 5 -> at most FIFO_DEPTH words outstanding+buffered; no loss, order preserved.
- count=0 on channel 1, start deasserted mid-pass -> pass completes to addr_high, then idle; chan_done[1]=1.
- low=5, high=2 on channel 3 -> cfg_err[3]=1, no reads to channel 3; other channels unaffected.
- sw_rst while 3 reads outstanding -> outputs zero next cycle; late responses are not emitted; next start behaves normally.
